sender: RTL and testbench

- Transmit-side bridge from the Galapagos AXI-Stream domain to the GULF UDP TX stream.
- Accepts 512-bit packets whose sideband carries the destination IP/port and source port.
- Latches that header on the first beat and holds it stable on the GULF side for the whole packet.
- Registers all outputs through a 2-entry skid buffer, and discards packets addressed to IP 0.0.0.0.

---
 rtl/galapagos_net_pkg.sv | 23 ++
 rtl/axis_skid_buf.sv | 87 ++++++++
 rtl/sender.sv | 171 +++++++++++++++++
 tb/tb_sender.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/galapagos_net_pkg.sv
// -----------------------------------------------------------------------------
// galapagos_net_pkg
// Shared definitions for the Galapagos <-> GULF network bridges.
//   IP_W / PORT_W / TUSER_W : field widths of the Galapagos sideband
//   TUSER_IP_LSB            : bit offset of the destination IPv4 in tuser
//   TUSER_PORT_LSB          : bit offset of the destination UDP port in tuser
//   state_e                 : per-packet input state (IDLE, FWD, DROP)
// -----------------------------------------------------------------------------
package galapagos_net_pkg;

  localparam int IP_W           = 32;
  localparam int PORT_W         = 16;
  localparam int TUSER_W        = 48;
  localparam int TUSER_IP_LSB   = 0;
  localparam int TUSER_PORT_LSB = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_e;

endpackage

// File: rtl/axis_skid_buf.sv
// -----------------------------------------------------------------------------
// axis_skid_buf
// Two-entry AXI-Stream register slice: an output register backed by one skid
// register. All outputs come straight from flops, so out_valid_o never depends
// combinationally on out_ready_i, and in_ready_o is a registered "skid empty".
// Sustains one beat per cycle when the consumer is always ready.
//   clk, rst_n               : clock, asynchronous active-low reset
//   in_valid_i/in_ready_o    : upstream handshake
//   in_data_i  [WIDTH]       : upstream payload
//   out_valid_o/out_ready_i  : downstream handshake
//   out_data_o [WIDTH]       : downstream payload
// -----------------------------------------------------------------------------
module axis_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             outValid_q,  outValid_d;
  logic [WIDTH-1:0] outData_q,   outData_d;
  logic             skidValid_q, skidValid_d;
  logic [WIDTH-1:0] skidData_q,  skidData_d;
  logic             ready_q,     ready_d;
  logic             inFire;
  logic             outFree;

  assign inFire  = in_valid_i & ready_q;
  assign outFree = ~outValid_q | out_ready_i;

  // Next-state of both entries. When the output register frees up it takes
  // the older skid entry first so ordering is preserved; otherwise a stalled
  // output pushes the incoming beat into the skid register. ready_q only
  // allows acceptance while the skid is empty, so an input beat can never
  // arrive while the skid entry is still waiting.
  always_comb begin
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    skidValid_d = skidValid_q;
    skidData_d  = skidData_q;
    if (outFree) begin
      if (skidValid_q) begin
        outValid_d  = 1'b1;
        outData_d   = skidData_q;
        skidValid_d = 1'b0;
      end else if (inFire) begin
        outValid_d = 1'b1;
        outData_d  = in_data_i;
      end else begin
        outValid_d = 1'b0;
      end
    end else if (inFire) begin
      skidValid_d = 1'b1;
      skidData_d  = in_data_i;
    end
    ready_d = ~skidValid_d;
  end

  // Storage for both entries plus the registered ready. Ready comes out of
  // reset low and rises on the first clock after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      skidValid_q <= 1'b0;
      skidData_q  <= '0;
      ready_q     <= 1'b0;
    end else begin
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      skidValid_q <= skidValid_d;
      skidData_q  <= skidData_d;
      ready_q     <= ready_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = outValid_q;
  assign out_data_o  = outData_q;

endmodule

// File: rtl/sender.sv
// -----------------------------------------------------------------------------
// sender
// Bridge from the Galapagos AXI-Stream domain to the GULF UDP TX stream.
// The destination IP/port and source port are taken from the first beat of a
// packet and carried alongside every beat through a 2-entry skid buffer, so
// the GULF-side header only changes when a new beat reaches the output.
// Packets addressed to IP 0.0.0.0 are accepted and discarded.
//   clk, resetn          : clock, asynchronous active-low reset
//   gal_t*               : Galapagos input stream (tuser = {dst port, dst ip},
//                          tdest = src port)
//   gulf_t*              : GULF TX stream
//   ip/src_prt/dst_prt   : header of the beat currently on gulf_t*
//   pkt_sent/pkt_dropped : statistics counters
// Configuration macro: SENDER_STATS_EN (defined = live counters, otherwise the
// counter ports are tied to zero and no counter registers exist).
// -----------------------------------------------------------------------------
module sender
  import galapagos_net_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                gal_tvalid,
  output logic                gal_tready,
  input  logic [DATA_W-1:0]   gal_tdata,
  input  logic [DATA_W/8-1:0] gal_tkeep,
  input  logic                gal_tlast,
  input  logic [TUSER_W-1:0]  gal_tuser,
  input  logic [PORT_W-1:0]   gal_tdest,
  output logic                gulf_tvalid,
  input  logic                gulf_tready,
  output logic [DATA_W-1:0]   gulf_tdata,
  output logic [DATA_W/8-1:0] gulf_tkeep,
  output logic                gulf_tlast,
  output logic [IP_W-1:0]     ip,
  output logic [PORT_W-1:0]   src_prt,
  output logic [PORT_W-1:0]   dst_prt,
  output logic [CNT_W-1:0]    pkt_sent,
  output logic [CNT_W-1:0]    pkt_dropped
);

  localparam int KEEP_W  = DATA_W / 8;
  localparam int ENTRY_W = DATA_W + KEEP_W + 1 + IP_W + 2 * PORT_W;

  state_e              state_q, state_d;
  logic [IP_W-1:0]     hdrIp_q,  hdrIp_d;
  logic [PORT_W-1:0]   hdrSrc_q, hdrSrc_d;
  logic [PORT_W-1:0]   hdrDst_q, hdrDst_d;
  logic                galFire;
  logic                ipIsZero;
  logic                push;
  logic [IP_W-1:0]     pushIp;
  logic [PORT_W-1:0]   pushSrc;
  logic [PORT_W-1:0]   pushDst;
  logic [ENTRY_W-1:0]  pushEntry;
  logic [ENTRY_W-1:0]  outEntry;

  assign galFire  = gal_tvalid & gal_tready;
  assign ipIsZero = (gal_tuser[TUSER_IP_LSB +: IP_W] == '0);

  // Input-side packet state and the latched header. Only accepted beats move
  // the machine; the header is captured on the first beat of a good packet.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      hdrIp_q  <= '0;
      hdrSrc_q <= '0;
      hdrDst_q <= '0;
    end else begin
      state_q  <= state_d;
      hdrIp_q  <= hdrIp_d;
      hdrSrc_q <= hdrSrc_d;
      hdrDst_q <= hdrDst_d;
    end
  end

  // Decide per accepted beat whether it is pushed into the buffer and with
  // which header. A first beat pushes the header straight from the sideband
  // because the latch only becomes visible a cycle later; later beats of the
  // packet reuse the latch and ignore any sideband changes.
  always_comb begin
    state_d  = state_q;
    hdrIp_d  = hdrIp_q;
    hdrSrc_d = hdrSrc_q;
    hdrDst_d = hdrDst_q;
    push     = 1'b0;
    pushIp   = hdrIp_q;
    pushSrc  = hdrSrc_q;
    pushDst  = hdrDst_q;
    case (state_q)
      IDLE: begin
        if (galFire) begin
          if (!ipIsZero) begin
            hdrIp_d  = gal_tuser[TUSER_IP_LSB +: IP_W];
            hdrDst_d = gal_tuser[TUSER_PORT_LSB +: PORT_W];
            hdrSrc_d = gal_tdest;
            pushIp   = gal_tuser[TUSER_IP_LSB +: IP_W];
            pushDst  = gal_tuser[TUSER_PORT_LSB +: PORT_W];
            pushSrc  = gal_tdest;
            push     = 1'b1;
            state_d  = gal_tlast ? IDLE : FWD;
          end else begin
            state_d = gal_tlast ? IDLE : DROP;
          end
        end
      end
      FWD: begin
        if (galFire) begin
          push = 1'b1;
          if (gal_tlast) begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (galFire && gal_tlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pushEntry = {gal_tdata, gal_tkeep, gal_tlast, pushIp, pushSrc, pushDst};

  axis_skid_buf #(
    .WIDTH(ENTRY_W)
  ) u_skid (
    .clk        (clk),
    .rst_n      (resetn),
    .in_valid_i (push),
    .in_ready_o (gal_tready),
    .in_data_i  (pushEntry),
    .out_valid_o(gulf_tvalid),
    .out_ready_i(gulf_tready),
    .out_data_o (outEntry)
  );

  assign {gulf_tdata, gulf_tkeep, gulf_tlast, ip, src_prt, dst_prt} = outEntry;

`ifdef SENDER_STATS_EN
  logic [CNT_W-1:0] pktSent_q;
  logic [CNT_W-1:0] pktDropped_q;
  logic             sentInc;
  logic             dropInc;

  // A good packet counts when its last beat is pushed; a dropped packet
  // counts on its first beat. Both wrap naturally at 2^CNT_W.
  assign sentInc = push & gal_tlast;
  assign dropInc = galFire & (state_q == IDLE) & ipIsZero;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pktSent_q    <= '0;
      pktDropped_q <= '0;
    end else begin
      pktSent_q    <= pktSent_q + CNT_W'(sentInc);
      pktDropped_q <= pktDropped_q + CNT_W'(dropInc);
    end
  end

  assign pkt_sent    = pktSent_q;
  assign pkt_dropped = pktDropped_q;
`else
  assign pkt_sent    = '0;
  assign pkt_dropped = '0;
`endif

endmodule

// File: tb/tb_sender.sv
// -----------------------------------------------------------------------------
// tb_sender
// Self-checking bench for sender. Packets are described at packet level
// (length, header, payload); the expected GULF stream is an in-order queue of
// forwarded beats, each tagged with its packet's first-beat header. Buffer
// occupancy is the queue depth: GULF valid whenever it is non-empty, Galapagos
// ready whenever fewer than two beats are held.
// -----------------------------------------------------------------------------
module tb_sender;

  localparam int DATA_W = 512;
  localparam int KEEP_W = DATA_W / 8;
  localparam int CNT_W  = 32;
`ifdef SENDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              resetn = 1'b1;
  logic              gal_tvalid = 1'b0;
  logic              gal_tready;
  logic [DATA_W-1:0] gal_tdata = '0;
  logic [KEEP_W-1:0] gal_tkeep = '0;
  logic              gal_tlast = 1'b0;
  logic [47:0]       gal_tuser = '0;
  logic [15:0]       gal_tdest = '0;
  logic              gulf_tvalid;
  logic              gulf_tready = 1'b1;
  logic [DATA_W-1:0] gulf_tdata;
  logic [KEEP_W-1:0] gulf_tkeep;
  logic              gulf_tlast;
  logic [31:0]       ip;
  logic [15:0]       src_prt;
  logic [15:0]       dst_prt;
  logic [CNT_W-1:0]  pkt_sent;
  logic [CNT_W-1:0]  pkt_dropped;

  sender #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .gal_tvalid (gal_tvalid),
    .gal_tready (gal_tready),
    .gal_tdata  (gal_tdata),
    .gal_tkeep  (gal_tkeep),
    .gal_tlast  (gal_tlast),
    .gal_tuser  (gal_tuser),
    .gal_tdest  (gal_tdest),
    .gulf_tvalid(gulf_tvalid),
    .gulf_tready(gulf_tready),
    .gulf_tdata (gulf_tdata),
    .gulf_tkeep (gulf_tkeep),
    .gulf_tlast (gulf_tlast),
    .ip         (ip),
    .src_prt    (src_prt),
    .dst_prt    (dst_prt),
    .pkt_sent   (pkt_sent),
    .pkt_dropped(pkt_dropped)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [31:0]       ip;
    logic [15:0]       src;
    logic [15:0]       dst;
  } beat_t;

  beat_t            expQ[$];
  int               testsRun    = 0;
  int               testsFailed = 0;
  logic [CNT_W-1:0] expSent     = '0;
  logic [CNT_W-1:0] expDropped  = '0;
  bit               randReady   = 1'b0;
  logic [7:0]       readyPat    = '0;
  int               patLen      = 0;
  int               patPos      = 0;
  bit               galAccepted = 1'b0;

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rndData();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // One clock cycle: choose gulf_tready, then at the falling edge check the
  // handshake signals against the model and retire any GULF transfer.
  // Returns at 1 unit after the rising edge so callers can drive new inputs.
  task automatic tick();
    beat_t e;
    if (patPos < patLen) begin
      gulf_tready = readyPat[patPos];
      patPos++;
    end else if (randReady) begin
      gulf_tready = 1'($urandom_range(0, 1));
    end else begin
      gulf_tready = 1'b1;
    end
    @(negedge clk);
    checkOutput("gal_tready", DATA_W'(gal_tready), DATA_W'(expQ.size() < 2));
    checkOutput("gulf_tvalid", DATA_W'(gulf_tvalid), DATA_W'(expQ.size() != 0));
    galAccepted = gal_tvalid && gal_tready;
    if (gulf_tvalid && gulf_tready && expQ.size() != 0) begin
      e = expQ.pop_front();
      checkOutput("gulf_tdata", gulf_tdata, e.data);
      checkOutput("gulf_tkeep", DATA_W'(gulf_tkeep), DATA_W'(e.keep));
      checkOutput("gulf_tlast", DATA_W'(gulf_tlast), DATA_W'(e.last));
      checkOutput("ip", DATA_W'(ip), DATA_W'(e.ip));
      checkOutput("src_prt", DATA_W'(src_prt), DATA_W'(e.src));
      checkOutput("dst_prt", DATA_W'(dst_prt), DATA_W'(e.dst));
    end
    @(posedge clk);
    #1;
  endtask

  // Drives one packet beat by beat, leaving gal_tvalid high afterwards so
  // consecutive calls produce back-to-back packets.
  task automatic applyStimulus(input int nBeats, input logic [31:0] ipv,
                               input logic [15:0] dport, input logic [15:0] sport,
                               input bit scramble, input bit zeroKeep);
    beat_t b;
    int    budget;
    for (int i = 0; i < nBeats; i++) begin
      b.data = rndData();
      b.keep = zeroKeep ? '0 : {$urandom, $urandom};
      b.last = (i == nBeats - 1);
      b.ip   = ipv;
      b.src  = sport;
      b.dst  = dport;
      gal_tvalid = 1'b1;
      gal_tdata  = b.data;
      gal_tkeep  = b.keep;
      gal_tlast  = b.last;
      if (i == 0 || !scramble) begin
        gal_tuser = {dport, ipv};
        gal_tdest = sport;
      end else begin
        gal_tuser = {16'($urandom), 32'($urandom)};
        gal_tdest = 16'($urandom);
      end
      budget = 0;
      do begin
        tick();
        budget++;
      end while (!galAccepted && budget < 64);
      if (!galAccepted) checkOutput("accept_timeout", DATA_W'(galAccepted), DATA_W'(1'b1));
      if (ipv != 32'd0) expQ.push_back(b);
    end
    if (ipv != 32'd0) expSent++;
    else expDropped++;
  endtask

  task automatic idle(input int n);
    gal_tvalid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic checkCounters();
    checkOutput("pkt_sent", DATA_W'(pkt_sent), DATA_W'(STATS ? expSent : {CNT_W{1'b0}}));
    checkOutput("pkt_dropped", DATA_W'(pkt_dropped),
                DATA_W'(STATS ? expDropped : {CNT_W{1'b0}}));
  endtask

  // Asserts reset, checks every cleared output immediately, releases it and
  // checks that ready rises only on the first clock after release.
  task automatic doReset();
    gal_tvalid = 1'b0;
    resetn     = 1'b0;
    #1;
    checkOutput("rst_gulf_tvalid", DATA_W'(gulf_tvalid), '0);
    checkOutput("rst_gulf_tdata", gulf_tdata, '0);
    checkOutput("rst_gulf_tkeep", DATA_W'(gulf_tkeep), '0);
    checkOutput("rst_gulf_tlast", DATA_W'(gulf_tlast), '0);
    checkOutput("rst_ip", DATA_W'(ip), '0);
    checkOutput("rst_src_prt", DATA_W'(src_prt), '0);
    checkOutput("rst_dst_prt", DATA_W'(dst_prt), '0);
    checkOutput("rst_gal_tready", DATA_W'(gal_tready), '0);
    checkOutput("rst_pkt_sent", DATA_W'(pkt_sent), '0);
    checkOutput("rst_pkt_dropped", DATA_W'(pkt_dropped), '0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("rel_gal_tready_low", DATA_W'(gal_tready), '0);
    @(posedge clk);
    #1;
    checkOutput("rel_gal_tready_high", DATA_W'(gal_tready), DATA_W'(1'b1));
    expQ.delete();
    expSent    = '0;
    expDropped = '0;
  endtask

  initial begin
    beat_t b;
    #1;
    doReset();

    // Basic 3-beat packet, header held afterwards.
    applyStimulus(3, 32'h0A000002, 16'h1234, 16'h5678, 1'b0, 1'b0);
    idle(3);
    checkCounters();
    checkOutput("ip_hold", DATA_W'(ip), DATA_W'(32'h0A000002));
    checkOutput("dst_hold", DATA_W'(dst_prt), DATA_W'(16'h1234));
    checkOutput("src_hold", DATA_W'(src_prt), DATA_W'(16'h5678));

    // Sideband scrambled after the first beat must be ignored.
    applyStimulus(3, 32'h0A000002, 16'h1234, 16'h5678, 1'b1, 1'b0);
    idle(3);
    checkCounters();

    // Dropped packet followed by a good single-beat packet.
    applyStimulus(2, 32'h00000000, 16'hAAAA, 16'hBBBB, 1'b0, 1'b0);
    applyStimulus(1, 32'hC0A80001, 16'h0050, 16'h1F90, 1'b0, 1'b0);
    idle(3);
    checkCounters();

    // Continuous input with GULF ready toggling 1,0,0,1.
    readyPat = 8'b0000_1001;
    patLen   = 4;
    patPos   = 0;
    applyStimulus(2, 32'h0A000010, 16'h0101, 16'h0202, 1'b0, 1'b0);
    applyStimulus(2, 32'h0A000011, 16'h0303, 16'h0404, 1'b0, 1'b0);
    applyStimulus(2, 32'h0A000012, 16'h0505, 16'h0606, 1'b0, 1'b0);
    idle(4);
    patLen = 0;
    checkCounters();

    // Back-to-back single-beat packets with distinct headers, then zero keep.
    applyStimulus(1, 32'h01020304, 16'h1111, 16'h2222, 1'b0, 1'b0);
    applyStimulus(1, 32'h05060708, 16'h3333, 16'h4444, 1'b0, 1'b0);
    applyStimulus(2, 32'h0B0B0B0B, 16'h5555, 16'h6666, 1'b0, 1'b1);
    idle(3);
    checkCounters();

    // Randomized packets with random GULF back-pressure.
    randReady = 1'b1;
    for (int p = 0; p < 24; p++) begin
      logic [31:0] rip;
      rip = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom | 32'd1);
      applyStimulus($urandom_range(1, 4), rip, 16'($urandom), 16'($urandom), 1'b1, 1'b0);
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    randReady = 1'b0;
    idle(6);
    checkCounters();

    // Reset in the middle of a packet with both buffer entries occupied.
    readyPat   = 8'h00;
    patLen     = 8;
    patPos     = 0;
    b.data     = rndData();
    b.keep     = '1;
    b.last     = 1'b0;
    b.ip       = 32'h0A0000FF;
    b.src      = 16'h2222;
    b.dst      = 16'h1111;
    gal_tvalid = 1'b1;
    gal_tdata  = b.data;
    gal_tkeep  = b.keep;
    gal_tlast  = 1'b0;
    gal_tuser  = {b.dst, b.ip};
    gal_tdest  = b.src;
    repeat (2) begin
      tick();
      if (galAccepted) expQ.push_back(b);
    end
    patLen = 0;
    doReset();
    applyStimulus(2, 32'h0A000003, 16'h7777, 16'h8888, 1'b0, 1'b0);
    idle(3);
    checkCounters();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
